// File: rtl/puf_cmd_controller.sv
// Command controller for a bank of PUF channels: decodes received frames,
// sequences a channel run with timeout, and emits registered response frames.
module puf_cmd_controller #(
    parameter int NCH  = 2,
    parameter int DW   = 128,
    parameter int CNTW = 16,
    parameter int TOW  = 20
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DW+7:0]     RX_FRAME,
    input  logic              RX_VALID,
    input  logic [NCH-1:0]    PUF_DONE,
    input  logic [NCH*DW-1:0] PUF_OUT,
    output logic [NCH-1:0]    PUF_START,
    output logic [CNTW-1:0]   CNT_VAL,
    output logic [DW+7:0]     TO_SEND,
    output logic              TX_VALID,
    output logic              BUSY,
    output logic              ERR
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [TOW-1:0] TO_LAST = {{(TOW-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_CAPTURE,
        S_RESPOND,
        S_FAULT
    } state_t;

    state_t                  state_q, state_d;
    logic [NCH-1:0]          puf_start_q, puf_start_d;
    logic [CNTW-1:0]         cnt_val_q, cnt_val_d;
    logic [DW+7:0]           to_send_q, to_send_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic                    ovr_q, ovr_d;
    logic [7:0]              frames_q, frames_d;
    logic [3:0]              ch_q, ch_d;
    logic [TOW-1:0]          to_cnt_q, to_cnt_d;
    logic [NCH-1:0][DW-1:0]  res_q, res_d;

    logic [NCH-1:0][DW-1:0]  puf_out_a;
    logic [7:0]              rx_op;
    logic [3:0]              rx_ch;
    logic [CHW-1:0]          rx_idx;
    logic [CHW-1:0]          ch_idx;
    logic [CNTW-1:0]         rx_cnt;
    logic                    rx_ch_ok;
    logic [DW-1:0]           status_w;
    logic                    err_set, err_clr, ovr_set;

    assign puf_out_a = PUF_OUT;
    assign rx_op     = RX_FRAME[DW+7:DW];
    assign rx_ch     = RX_FRAME[DW-1:DW-4];
    assign rx_idx    = rx_ch[CHW-1:0];
    assign ch_idx    = ch_q[CHW-1:0];
    assign rx_cnt    = RX_FRAME[CNTW-1:0];
    assign rx_ch_ok  = (32'(rx_ch) < NCH);

    always_comb begin
        status_w = '0;
        status_w[NCH+9:0] = {ovr_q, err_q, PUF_DONE, frames_q};
    end

    always_comb begin
        state_d     = state_q;
        puf_start_d = puf_start_q;
        cnt_val_d   = cnt_val_q;
        to_send_d   = to_send_q;
        tx_valid_d  = 1'b0;
        frames_d    = frames_q;
        ch_d        = ch_q;
        to_cnt_d    = to_cnt_q;
        res_d       = res_q;
        err_set     = 1'b0;
        err_clr     = 1'b0;
        ovr_set     = RX_VALID && (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (RX_VALID) begin
                    frames_d   = frames_q + 8'd1;
                    tx_valid_d = 1'b1;
                    state_d    = S_RESPOND;
                    case (rx_op)
                        8'h01: begin
                            if (rx_ch_ok) begin
                                state_d     = S_RUN;
                                tx_valid_d  = 1'b0;
                                puf_start_d = NCH'(1) << rx_idx;
                                cnt_val_d   = (rx_cnt == '0) ? CNTW'(1) : rx_cnt;
                                to_cnt_d    = '0;
                                ch_d        = rx_ch;
                            end else begin
                                state_d   = S_FAULT;
                                err_set   = 1'b1;
                                to_send_d = {8'hFF, {(DW-8){1'b0}}, rx_op};
                            end
                        end
                        8'h02: begin
                            if (rx_ch_ok) begin
                                to_send_d = {8'h02, res_q[rx_idx]};
                            end else begin
                                state_d   = S_FAULT;
                                err_set   = 1'b1;
                                to_send_d = {8'hFF, {(DW-8){1'b0}}, rx_op};
                            end
                        end
                        8'h03: to_send_d = {8'h03, RX_FRAME[DW-1:0]};
                        8'h04: to_send_d = {8'h04, status_w};
                        8'h05: begin
                            err_clr   = 1'b1;
                            to_send_d = {8'h05, {DW{1'b0}}};
                        end
                        default: begin
                            state_d   = S_FAULT;
                            err_set   = 1'b1;
                            to_send_d = {8'hFF, {(DW-8){1'b0}}, rx_op};
                        end
                    endcase
                end
            end
            S_RUN: begin
                // Done takes priority over a timeout landing on the same edge
                if (PUF_DONE[ch_idx]) begin
                    state_d         = S_CAPTURE;
                    puf_start_d     = '0;
                    res_d[ch_idx]   = puf_out_a[ch_idx];
                    to_send_d       = {8'h01, puf_out_a[ch_idx]};
                    tx_valid_d      = 1'b1;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d     = S_FAULT;
                    puf_start_d = '0;
                    err_set     = 1'b1;
                    to_send_d   = {8'hFE, {(DW-4){1'b0}}, ch_q};
                    tx_valid_d  = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TOW'(1);
                end
            end
            S_CAPTURE: state_d = S_IDLE;
            S_RESPOND: state_d = S_IDLE;
            S_FAULT:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        err_d  = (err_q & ~err_clr) | err_set;
        ovr_d  = (ovr_q & ~err_clr) | ovr_set;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            puf_start_q <= '0;
            cnt_val_q   <= CNTW'(1);
            to_send_q   <= '0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            ovr_q       <= 1'b0;
            frames_q    <= '0;
            ch_q        <= '0;
            to_cnt_q    <= '0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            puf_start_q <= puf_start_d;
            cnt_val_q   <= cnt_val_d;
            to_send_q   <= to_send_d;
            tx_valid_q  <= tx_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            ovr_q       <= ovr_d;
            frames_q    <= frames_d;
            ch_q        <= ch_d;
            to_cnt_q    <= to_cnt_d;
            res_q       <= res_d;
        end
    end

    assign PUF_START = puf_start_q;
    assign CNT_VAL   = cnt_val_q;
    assign TO_SEND   = to_send_q;
    assign TX_VALID  = tx_valid_q;
    assign BUSY      = busy_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_puf_cmd_controller.sv
// Testbench for puf_cmd_controller: directed and randomized commands checked
// against a transaction-level model of results, error flags and frame counts.
module tb_puf_cmd_controller;

    localparam int NCH  = 4;
    localparam int DW   = 128;
    localparam int CNTW = 16;
    localparam int TOW  = 4;
    localparam int TO_CYC = 15;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic [DW+7:0]     RX_FRAME = '0;
    logic              RX_VALID = 1'b0;
    logic [NCH-1:0]    PUF_DONE = '0;
    logic [NCH*DW-1:0] PUF_OUT = '0;
    logic [NCH-1:0]    PUF_START;
    logic [CNTW-1:0]   CNT_VAL;
    logic [DW+7:0]     TO_SEND;
    logic              TX_VALID;
    logic              BUSY;
    logic              ERR;

    int n_cmp = 0;
    int n_fail = 0;

    logic [DW-1:0] res_m [NCH];
    logic          err_m;
    logic          ovr_m;
    logic [7:0]    frames_m;

    puf_cmd_controller #(
        .NCH (NCH),
        .DW  (DW),
        .CNTW(CNTW),
        .TOW (TOW)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .RX_FRAME (RX_FRAME),
        .RX_VALID (RX_VALID),
        .PUF_DONE (PUF_DONE),
        .PUF_OUT  (PUF_OUT),
        .PUF_START(PUF_START),
        .CNT_VAL  (CNT_VAL),
        .TO_SEND  (TO_SEND),
        .TX_VALID (TX_VALID),
        .BUSY     (BUSY),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [135:0] obs,
                         input logic [135:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [DW+7:0] mk(input logic [7:0] op, input int ch,
                                         input logic [15:0] cnt);
        logic [DW-1:0] p;
        p = rnd_word();
        p[DW-1:DW-4] = 4'(ch);
        p[15:0] = cnt;
        return {op, p};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) res_m[i] = '0;
        err_m = 1'b0;
        ovr_m = 1'b0;
        frames_m = 8'd0;
    endtask

    task automatic send(input logic [DW+7:0] fr);
        RX_FRAME = fr;
        RX_VALID = 1'b1;
        tick();
        RX_VALID = 1'b0;
    endtask

    task automatic randomize_outs();
        for (int k = 0; k < NCH; k++) PUF_OUT[k*DW +: DW] = rnd_word();
    endtask

    // Single-cycle commands (everything except a legal RUN)
    task automatic do_cmd(input logic [7:0] op, input int ch);
        logic [DW+7:0] fr;
        logic [DW+7:0] exp;
        logic [DW-1:0] stat;
        logic [NCH-1:0] snap;
        bit illegal;
        fr = mk(op, ch, 16'($urandom()));
        snap = NCH'($urandom());
        PUF_DONE = snap;
        illegal = 1'b0;
        exp = '0;
        case (op)
            8'h01: illegal = 1'b1;
            8'h02: if (ch < NCH) exp = {8'h02, res_m[ch]};
                   else illegal = 1'b1;
            8'h03: exp = {8'h03, fr[DW-1:0]};
            8'h04: begin
                stat = '0;
                stat[NCH+9:0] = {ovr_m, err_m, snap, frames_m};
                exp = {8'h04, stat};
            end
            8'h05: begin
                exp = {8'h05, {DW{1'b0}}};
                err_m = 1'b0;
                ovr_m = 1'b0;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            exp = {8'hFF, {(DW-8){1'b0}}, op};
            err_m = 1'b1;
        end
        frames_m = frames_m + 8'd1;
        send(fr);
        PUF_DONE = '0;
        check("cmd_tx_valid", TX_VALID, 1);
        check("cmd_to_send", TO_SEND, exp);
        check("cmd_err", ERR, err_m);
        check("cmd_busy", BUSY, 1);
        check("cmd_no_start", PUF_START, 0);
        tick();
        check("cmd_tx_drop", TX_VALID, 0);
        check("cmd_idle", BUSY, 0);
        check("cmd_hold", TO_SEND, exp);
    endtask

    // Legal RUN; done on the channel in RUN cycle d (1-based), none if d > 15.
    task automatic do_run(input int ch, input logic [15:0] cnt, input int d,
                          input int ovr_cyc, input bit a5);
        logic [NCH-1:0] oh;
        logic [DW-1:0] cap;
        logic [DW+7:0] exp;
        int ncyc, on, early;
        oh = NCH'(1) << ch;
        ncyc = (d >= 1 && d <= TO_CYC) ? d : TO_CYC;
        cap = '0;
        on = 0;
        early = 0;
        frames_m = frames_m + 8'd1;
        send(mk(8'h01, ch, cnt));
        check("run_start", PUF_START, oh);
        check("run_cnt_val", CNT_VAL, (cnt == 16'd0) ? 16'd1 : cnt);
        check("run_busy", BUSY, 1);
        for (int k = 1; k <= ncyc; k++) begin
            if (PUF_START === oh) on++;
            if (TX_VALID !== 1'b0) early++;
            randomize_outs();
            if (a5) PUF_OUT[ch*DW +: DW] = {(DW/8){8'hA5}};
            PUF_DONE = NCH'($urandom()) & ~oh;
            if (k == d) begin
                PUF_DONE = PUF_DONE | oh;
                cap = PUF_OUT[ch*DW +: DW];
            end
            if (k == ovr_cyc) begin
                RX_FRAME = mk(8'h03, 0, 16'($urandom()));
                RX_VALID = 1'b1;
                ovr_m = 1'b1;
            end
            tick();
            RX_VALID = 1'b0;
        end
        PUF_DONE = '0;
        check("run_start_cycles", on, ncyc);
        check("run_no_early_tx", early, 0);
        if (d >= 1 && d <= TO_CYC) begin
            exp = {8'h01, cap};
            res_m[ch] = cap;
        end else begin
            exp = {8'hFE, {(DW-4){1'b0}}, 4'(ch)};
            err_m = 1'b1;
        end
        check("run_tx_valid", TX_VALID, 1);
        check("run_to_send", TO_SEND, exp);
        check("run_start_off", PUF_START, 0);
        check("run_err", ERR, err_m);
        check("run_busy_resp", BUSY, 1);
        tick();
        check("run_tx_drop", TX_VALID, 0);
        check("run_idle", BUSY, 0);
        check("run_hold", TO_SEND, exp);
    endtask

    initial begin
        int r, ch, d;
        model_reset();
        RESET = 1'b1;
        repeat (3) tick();
        check("rst_start", PUF_START, 0);
        check("rst_cnt_val", CNT_VAL, 1);
        check("rst_to_send", TO_SEND, 0);
        check("rst_tx_valid", TX_VALID, 0);
        check("rst_busy", BUSY, 0);
        check("rst_err", ERR, 0);

        // First frame lands on the very first edge with reset released
        RESET = 1'b0;
        do_cmd(8'h02, 1);

        do_run(2, 16'h0010, 5, 0, 1'b1);
        do_run(1, 16'h0000, 6, 0, 1'b0);
        do_cmd(8'h02, 1);

        do_run(0, 16'h0033, 0, 0, 1'b0);
        do_cmd(8'h04, 0);
        do_cmd(8'h05, 0);
        check("clrerr_err", ERR, 0);

        do_run(3, 16'h0100, 7, 2, 1'b0);
        do_cmd(8'h04, 0);
        do_cmd(8'h07, 0);
        do_cmd(8'h01, 5);
        do_cmd(8'h02, 9);
        do_cmd(8'h05, 0);
        do_cmd(8'h03, 2);
        do_run(0, 16'h0001, 1, 0, 1'b0);
        do_run(1, 16'hFFFF, 15, 0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 7);
            case (r)
                0, 1: begin
                    ch = $urandom_range(0, NCH-1);
                    d = $urandom_range(1, 18);
                    do_run(ch, ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom()),
                           d, ($urandom_range(0, 3) == 0) ? 1 : 0, 1'b0);
                end
                2: do_cmd(8'h02, $urandom_range(0, 5));
                3: do_cmd(8'h03, $urandom_range(0, 15));
                4: do_cmd(8'h04, 0);
                5: do_cmd(8'h05, 0);
                6: do_cmd(8'($urandom_range(6, 255)), $urandom_range(0, 15));
                default: do_cmd(8'h01, $urandom_range(NCH, 15));
            endcase
        end

        // Reset in the third RUN cycle aborts the command silently
        send(mk(8'h01, 3, 16'h0007));
        PUF_DONE = '0;
        tick();
        tick();
        RESET = 1'b1;
        tick();
        model_reset();
        check("abort_start", PUF_START, 0);
        check("abort_to_send", TO_SEND, 0);
        check("abort_tx_valid", TX_VALID, 0);
        check("abort_busy", BUSY, 0);
        check("abort_cnt_val", CNT_VAL, 1);
        check("abort_err", ERR, 0);
        RESET = 1'b0;
        do_run(3, 16'h0020, 4, 0, 1'b0);
        do_cmd(8'h02, 3);
        do_cmd(8'h02, 2);
        do_cmd(8'h04, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/puf_cmd_controller.md
PUF_CMD_CONTROLLER -- requirements
Module: puf_cmd_controller

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NCH, 2, number of PUF channels (1..16).
- DW, 128, PUF response width.
- CNTW, 16, stimulus count width.
- TOW, 20, timeout counter width.
REQ-002 Ports (name, direction, width, meaning), one per line:
- CLK, in, 1, single clock.
- RESET, in, 1, synchronous reset, active-high.
- RX_FRAME, in, 8+DW, received frame; opcode = [DW+7:DW], channel = [DW-1:DW-4], count = [CNTW-1:0].
- RX_VALID, in, 1, one-cycle strobe marking a new RX_FRAME.
- PUF_DONE, in, NCH, per-channel done.
- PUF_OUT, in, NCH*DW, channel k response on [k*DW+:DW].
- PUF_START, out, NCH, one-hot run enable.
- CNT_VAL, out, CNTW, stimulus count to the active channel.
- TO_SEND, out, 8+DW, response frame.
- TX_VALID, out, 1, one-cycle strobe when TO_SEND is updated.
- BUSY, out, 1, controller not in IDLE.
- ERR, out, 1, sticky error flag.
REQ-003 Clock and reset: one clock (CLK); reset is synchronous and active-high (RESET).

Function
REQ-004 Registered outputs:
- All outputs SHALL be registered.
- Opcodes: 0x01 RUN, 0x02 READ, 0x03 ECHO, 0x04 STATUS, 0x05 CLRERR.
- Any other opcode is ILLEGAL.
REQ-005 States: IDLE, RUN, CAPTURE, RESPOND, FAULT.
REQ-006 Frame acceptance:
- A frame is accepted only when RX_VALID=1 and the state is IDLE.
- RX_VALID in any other state is dropped and sets status bit OVR.
REQ-007 RUN with channel < NCH:
- IDLE -> RUN on the next edge.
- In RUN, PUF_START[ch]=1 and CNT_VAL=count; a count of 0 is substituted by 1.
- Timeout counter loads 0.
REQ-008 RUN -> CAPTURE on the first edge with PUF_DONE[ch]=1.
- PUF_DONE on other channels is ignored.
- PUF_DONE already high on the first RUN cycle counts as done.
REQ-009 CAPTURE:
- PUF_START=0; result register RES[ch] <= PUF_OUT[ch].
- TO_SEND <= {0x01, PUF_OUT[ch]}; TX_VALID=1 for one cycle.
- Next state: IDLE.
REQ-010 Timeout:
- The counter increments each RUN cycle.
- When it reaches 2^TOW-1 with no done: RUN -> FAULT, set ERR, TO_SEND <= {0xFE, DW'ch}, TX_VALID pulse.
- Next state: IDLE.
REQ-011 READ (channel < NCH):
- One cycle after acceptance: TO_SEND <= {0x02, RES[ch]}, TX_VALID pulse.
- Returns the last captured value, or 0 since reset.
REQ-012 ECHO: TO_SEND <= RX_FRAME as accepted, with opcode byte 0x03; TX_VALID pulse; latency 1.
REQ-013 STATUS: TO_SEND <= {0x04, zero-padded {OVR, ERR, NCH-bit PUF_DONE snapshot, 8-bit frames-accepted counter}}; latency 1.
- The frames-accepted counter wraps 255 -> 0.
REQ-014 CLRERR: clears ERR and OVR; TO_SEND <= {0x05, 0}; TX_VALID pulse.
REQ-015 Illegal opcode, or RUN/READ with channel >= NCH:
- FAULT, set ERR, TO_SEND <= {0xFF, DW'opcode}, TX_VALID pulse.
- PUF_START never asserted.
REQ-016 TO_SEND holds its value between TX_VALID pulses.
REQ-017 BUSY=1 in every state except IDLE.
REQ-018 ERR and OVR are sticky until CLRERR or RESET.
- Set and clear in the same cycle: set wins.

Reset
REQ-019 RESET=1 sampled at an edge SHALL force:
- state IDLE;
- PUF_START=0, CNT_VAL=1, TO_SEND=0, TX_VALID=0, BUSY=0, ERR=0, OVR=0;
- all RES[k]=0; frames counter=0.
REQ-020 Reset mid-RUN drops PUF_START on the following edge; no TX_VALID is emitted for the aborted command.
REQ-021 The first frame is accepted on the first edge with RESET=0.

Verification
REQ-022 NCH=4. RUN ch2 count 0x0010, PUF_DONE[2] after 5 cycles, PUF_OUT ch2=0xA5...A5.
- PUF_START=4'b0100, CNT_VAL=0x0010.
- One TX_VALID with TO_SEND={0x01, A5..A5}.
- BUSY falls the cycle after TX_VALID.
REQ-023 RUN ch1 count 0.
- CNT_VAL=1.
- PUF_DONE[0] pulses are ignored; done on ch1 completes the command.
- Subsequent READ ch1 returns {0x02, captured value}.
REQ-024 TOW=4. RUN ch0, no PUF_DONE.
- After 15 RUN cycles: TO_SEND={0xFE, 0}, ERR=1.
- STATUS then reports ERR=1; CLRERR clears it.
REQ-025 Overrun and illegal cases:
- RX_VALID pulse during RUN: frame dropped; STATUS shows OVR=1 and the accepted count excludes it.
- Opcode 0x07: TO_SEND={0xFF, 0x07}, no PUF_START.
- RUN ch5 with NCH=4: same error path.
REQ-026 RESET asserted on the 3rd RUN cycle.
- Next edge: PUF_START=0, TO_SEND=0, no TX_VALID.
- A RUN issued immediately after reset completes normally.
